// File: rtl/apb4_rr_master.sv
// Two-requester APB4 master: round-robin grant, SETUP/ACCESS sequencing, response return.
// Optional ACCESS timeout enabled by defining APB4_RR_MASTER_TIMEOUT_EN.
module apb4_rr_master #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB_WIDTH-1:0] req_strb,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [STRB_WIDTH-1:0]   PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb4_rr_master: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                 state_q;
  logic                   prio_q;
  logic                   gnt_q;
  logic                   gnt_d;
  logic                   any_valid;
  logic [1:0]             rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   rsp_err_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic [STRB_WIDTH-1:0]  pstrb_q;

  logic [ADDR_WIDTH-1:0]  addr_k  [2];
  logic [DATA_WIDTH-1:0]  wdata_k [2];
  logic [STRB_WIDTH-1:0]  strb_k  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign addr_k[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_k[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign strb_k[gi]  = req_strb[gi*STRB_WIDTH +: STRB_WIDTH];
  end

`ifdef APB4_RR_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    any_valid = |req_valid;
    gnt_d     = (&req_valid) ? prio_q : req_valid[1];
    req_ready = 2'b00;
    if (state_q == S_IDLE && any_valid && !PRESET) begin
      req_ready = gnt_d ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
`ifdef APB4_RR_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            pwrite_q <= req_write[gnt_d];
            paddr_q  <= addr_k[gnt_d];
            pwdata_q <= wdata_k[gnt_d];
            pstrb_q  <= strb_k[gnt_d];
            gnt_q    <= gnt_d;
            prio_q   <= ~gnt_d;
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
`ifdef APB4_RR_MASTER_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        S_ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_err_q   <= PSLVERR;
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
`ifdef APB4_RR_MASTER_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the stalled completer and report an error to the owner.
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule
